// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one WIDTH-bit adder among NREQ requesters.
// Define ADDER_SCHED_CARRY_EN to add the registered rsp_carry output.
module adder_rr_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WIDTH-1:0]    req_a,
  input  logic [NREQ*WIDTH-1:0]    req_b,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [WIDTH-1:0]         rsp_sum
`ifdef ADDER_SCHED_CARRY_EN
  ,
  output logic                     rsp_carry
`endif
);

  // state | meaning
  // IDLE  | offering a grant to the next valid requester
  // CALC  | operands captured, sum being registered
  // RESP  | response presented, waiting for rsp_ready
  localparam int IDW = $clog2(NREQ);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   grant_id;
  logic [IDW-1:0]   cand;
  logic             found;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [IDW-1:0]   op_id;
  logic             transfer;

  // Rotating search: start one past the last winner so every requester gets a turn.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    cand     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_grant) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found    = 1'b1;
        grant_id = cand;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == grant_id) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && found) req_ready[grant_id] = 1'b1;
  end

  assign transfer  = (state == IDLE) && found;
  assign rsp_valid = (state == RESP);

`ifdef ADDER_SCHED_CARRY_EN
  logic [WIDTH:0] full_sum;
  assign full_sum = {1'b0, op_a} + {1'b0, op_b};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= IDW'(NREQ - 1);
      op_a       <= '0;
      op_b       <= '0;
      op_id      <= '0;
      rsp_id     <= '0;
      rsp_sum    <= '0;
`ifdef ADDER_SCHED_CARRY_EN
      rsp_carry  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (transfer) begin
            op_a       <= sel_a;
            op_b       <= sel_b;
            op_id      <= grant_id;
            last_grant <= grant_id;
            state      <= CALC;
          end
        end
        CALC: begin
          rsp_id    <= op_id;
`ifdef ADDER_SCHED_CARRY_EN
          rsp_sum   <= full_sum[WIDTH-1:0];
          rsp_carry <= full_sum[WIDTH];
`else
          rsp_sum   <= op_a + op_b;
`endif
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Scoreboard bench for adder_rr_scheduler: directed vectors push expected
// responses, an independent monitor pops and compares on each handshake.
module tb_adder_rr_scheduler;
  localparam int NREQ  = 4;
  localparam int WIDTH = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [1:0]            rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
`ifdef ADDER_SCHED_CARRY_EN
  logic                  rsp_carry;
`endif

  typedef struct {
    logic [1:0] id;
    logic [3:0] sum;
    logic       carry;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  adder_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum)
`ifdef ADDER_SCHED_CARRY_EN
    ,
    .rsp_carry (rsp_carry)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [3:0] sum, input logic carry);
    exp_t e;
    e.id    = id;
    e.sum   = sum;
    e.carry = carry;
    sb.push_back(e);
  endtask

  task automatic set_req(input int id, input logic [3:0] a, input logic [3:0] b);
    req_valid[id]     = 1'b1;
    req_a[id*4 +: 4]  = a;
    req_b[id*4 +: 4]  = b;
  endtask

  task automatic await_grant(input string name, input logic [3:0] exp_g);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready != '0) break;
    end
    chk(name, 32'(req_ready), 32'(exp_g));
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !rsp_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual_pending=%0d expected_pending=0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every accepted response against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp actual_id=%0d actual_sum=%0h expected=none", rsp_id, rsp_sum);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_sum", 32'(rsp_sum), 32'(e.sum));
`ifdef ADDER_SCHED_CARRY_EN
          chk("rsp_carry", 32'(rsp_carry), 32'(e.carry));
`endif
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  logic [3:0] order [5];
  logic [3:0] ta [4];
  logic [3:0] tb [4];
  logic [3:0] ts [4];
  logic       tc [4];

  initial begin
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    ta = '{4'h2, 4'h9, 4'h7, 4'hC};
    tb = '{4'h3, 4'h8, 4'h7, 4'h5};
    ts = '{4'h5, 4'h1, 4'hE, 4'h1};
    tc = '{1'b0, 1'b1, 1'b0, 1'b1};

    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_sum", 32'(rsp_sum), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
`ifdef ADDER_SCHED_CARRY_EN
    chk("rst_rsp_carry", 32'(rsp_carry), 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // test 1: single requester 0, latency, operands sampled at accept only
    set_req(0, 4'b0011, 4'b1000);
    await_grant("t1_grant", 4'b0001);
    push_exp(2'd0, 4'b1011, 1'b0);
    @(posedge clk); #1;
    req_valid = '0;
    req_a     = '1;
    req_b     = '1;
    @(negedge clk);
    chk("t1_calc_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t1_calc_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("t1_resp_rsp_valid", 32'(rsp_valid), 32'd1);
    drain();

    // test 2: requester 2 twice
    set_req(2, 4'b0001, 4'b0100);
    await_grant("t2a_grant", 4'b0100);
    push_exp(2'd2, 4'b0101, 1'b0);
    @(posedge clk); #1;
    req_valid = '0;
    drain();
    set_req(2, 4'b0101, 4'b1000);
    await_grant("t2b_grant", 4'b0100);
    push_exp(2'd2, 4'b1101, 1'b0);
    @(posedge clk); #1;
    req_valid = '0;
    req_a     = '0;
    drain();

    // test 4: overflow wrap
    set_req(1, 4'b1111, 4'b0001);
    await_grant("t4_grant", 4'b0010);
    push_exp(2'd1, 4'b0000, 1'b1);
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // test 5: backpressure in RESP, competing request must not be granted
    rsp_ready = 1'b0;
    set_req(3, 4'b0110, 4'b0111);
    await_grant("t5_grant", 4'b1000);
    push_exp(2'd3, 4'b1101, 1'b0);
    @(posedge clk); #1;
    req_valid = '0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    @(posedge clk); #1;
    set_req(0, 4'h4, 4'h4);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("t5_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t5_hold_id", 32'(rsp_id), 32'd3);
      chk("t5_hold_sum", 32'(rsp_sum), 32'hD);
      chk("t5_hold_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req_valid = '0;
    drain();

    // test 3: all requesters valid, rotation from last winner 3
    for (int i = 0; i < 4; i++) set_req(i, ta[i], tb[i]);
    for (int g = 0; g < 5; g++) begin
      int id;
      id = (g == 4) ? 0 : g;
      await_grant($sformatf("t3_grant%0d", g), order[g]);
      push_exp(2'(id), ts[id], tc[id]);
      @(posedge clk); #1;
    end
    req_valid = '0;
    drain();

    // test 6: reset during CALC discards the transaction
    set_req(0, 4'h1, 4'h1);
    await_grant("t6_grant", 4'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    rst_n     = 1'b0;
    @(negedge clk);
    chk("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t6_rst_rsp_sum", 32'(rsp_sum), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("t6_no_rsp", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    for (int i = 1; i < 4; i++) set_req(i, ta[i], tb[i]);
    set_req(0, 4'h1, 4'h1);
    await_grant("t6_prio_after_rst", 4'b0001);
    push_exp(2'd0, 4'h2, 1'b0);
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
